mem_arbiter: RTL and testbench

Shared main-memory arbiter for the cached CPU. It sits between the instruction-cache miss path, the data-cache miss/write path and the single multi-cycle main memory. It grants the memory to one requester at a time and sequences block fills (one address issued per cycle, words counted back as they return) and single-word writes. It is the only block that drives main-memory address, enable and write.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester and main-memory signal bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    // Requester side
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_grant;
    logic        d_grant;
    logic [15:0] fill_data;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic [2:0]  fill_word_idx;
    logic        i_done;
    logic        d_done;

    // Main-memory side
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;

    // The arbiter
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_data_out, mem_data_valid,
        output i_grant, d_grant, fill_data, i_fill_valid, d_fill_valid,
        output fill_word_idx, i_done, d_done,
        output mem_addr, mem_enable, mem_wr, mem_data_in
    );

    // Caches plus main memory
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_data_out, mem_data_valid,
        input  i_grant, d_grant, fill_data, i_fill_valid, d_fill_valid,
        input  fill_word_idx, i_done, d_done,
        input  mem_addr, mem_enable, mem_wr, mem_data_in
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Grants main memory to the I- or D-cache; sequences block
//               fills and single-word writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int c_N  = $clog2(BLOCK_WORDS);
    localparam int c_CW = c_N + 1;

    localparam logic [c_CW-1:0] c_FULL = c_CW'(BLOCK_WORDS);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BLOCK_WORDS - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_I_FILL  = 2'd1;
    localparam logic [1:0] S_D_FILL  = 2'd2;
    localparam logic [1:0] S_D_WRITE = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_issue_cnt;
    logic [c_CW-1:0] r_ret_cnt;
    logic [15:0]     r_addr;
    logic [15:0]     r_wdata;

    logic            w_in_fill;
    logic            w_issue;
    logic            w_ret;
    logic            w_last;
    logic [15:0]     w_fill_addr;
    logic [2:0]      w_idx;

    assign w_in_fill   = (r_state == S_I_FILL) || (r_state == S_D_FILL);
    assign w_issue     = w_in_fill && (r_issue_cnt < c_FULL);
    assign w_ret       = w_in_fill && bus.mem_data_valid;
    assign w_last      = w_ret && (r_ret_cnt == c_LAST);
    // Word address within the block, scaled by two for the 16-bit word size
    assign w_fill_addr = {r_addr[15:c_N+1], r_issue_cnt[c_N-1:0], 1'b0};

    always_comb begin
        w_idx             = '0;
        w_idx[c_N-1:0]    = r_ret_cnt[c_N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_issue_cnt <= '0;
                    r_ret_cnt   <= '0;
                    // The D side always wins: its miss is for an older instruction
                    if (bus.d_req && bus.d_wr) begin
                        r_state <= S_D_WRITE;
                        r_addr  <= bus.d_addr;
                        r_wdata <= bus.d_wdata;
                    end else if (bus.d_req) begin
                        r_state <= S_D_FILL;
                        r_addr  <= bus.d_addr;
                    end else if (bus.i_req) begin
                        r_state <= S_I_FILL;
                        r_addr  <= bus.i_addr;
                    end
                end
                S_I_FILL, S_D_FILL: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + c_ONE;
                    end
                    if (w_ret) begin
                        r_ret_cnt <= r_ret_cnt + c_ONE;
                    end
                    if (w_last) begin
                        r_state     <= S_IDLE;
                        r_issue_cnt <= '0;
                        r_ret_cnt   <= '0;
                    end
                end
                S_D_WRITE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fill_data = bus.mem_data_out;

    always_comb begin
        bus.mem_addr      = '0;
        bus.mem_enable    = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_data_in   = '0;
        bus.i_grant       = 1'b0;
        bus.d_grant       = 1'b0;
        bus.i_fill_valid  = 1'b0;
        bus.d_fill_valid  = 1'b0;
        bus.fill_word_idx = '0;
        bus.i_done        = 1'b0;
        bus.d_done        = 1'b0;

        if (w_in_fill) begin
            bus.fill_word_idx = w_idx;
            if (w_issue) begin
                bus.mem_enable = 1'b1;
                bus.mem_addr   = w_fill_addr;
            end
        end

        case (r_state)
            S_I_FILL: begin
                bus.i_grant      = 1'b1;
                bus.i_fill_valid = bus.mem_data_valid;
                bus.i_done       = w_last;
            end
            S_D_FILL: begin
                bus.d_grant      = 1'b1;
                bus.d_fill_valid = bus.mem_data_valid;
                bus.d_done       = w_last;
            end
            S_D_WRITE: begin
                bus.d_grant     = 1'b1;
                bus.d_done      = 1'b1;
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = r_addr;
                bus.mem_data_in = r_wdata;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter, memory latency 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.BLOCK_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: read data (inverted address) returns 4 cycles after issue
    logic [3:0]  vld  = '0;
    logic [15:0] dat0 = '0, dat1 = '0, dat2 = '0, dat3 = '0;
    logic        inj  = 1'b0;

    always @(posedge clk) begin
        vld  <= {vld[2:0], bus.mem_enable & ~bus.mem_wr};
        dat0 <= ~bus.mem_addr;
        dat1 <= dat0;
        dat2 <= dat1;
        dat3 <= dat2;
    end

    assign bus.mem_data_valid = vld[3] | inj;
    assign bus.mem_data_out   = inj ? 16'h7777 : dat3;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        checks++;
        if ({bus.mem_addr, bus.mem_data_in, bus.mem_enable, bus.mem_wr, bus.i_grant, bus.d_grant,
             bus.i_fill_valid, bus.d_fill_valid, bus.fill_word_idx, bus.i_done, bus.d_done} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h wdata=%h en=%b wr=%b ig=%b dg=%b, required all 0",
                     bus.mem_addr, bus.mem_data_in, bus.mem_enable, bus.mem_wr, bus.i_grant, bus.d_grant);
        end
        checks++;
        if (bus.fill_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_fill_data: got %h required ffff", bus.fill_data);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_i_fill;
        logic       eg, ee, ev, ed;
        logic [15:0] ea, edat;
        step();
        bus.i_req = 1'b1; bus.i_addr = 16'h1234;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            eg = (k >= 1 && k <= 12);
            ee = (k >= 1 && k <= 8);
            ev = (k >= 5 && k <= 12);
            ed = (k == 12);
            ea = ee ? 16'h1230 + 16'(2 * (k - 1)) : 16'h0000;
            checks++;
            if ({bus.i_grant, bus.d_grant, bus.mem_enable, bus.mem_wr, bus.i_fill_valid,
                 bus.d_fill_valid, bus.i_done, bus.d_done} !== {eg, 1'b0, ee, 1'b0, ev, 1'b0, ed, 1'b0}) begin
                errors++;
                $display("FAIL i_fill_flags k=%0d: got ig=%b dg=%b en=%b wr=%b iv=%b dv=%b id=%b dd=%b, required ig=%b en=%b iv=%b id=%b",
                         k, bus.i_grant, bus.d_grant, bus.mem_enable, bus.mem_wr, bus.i_fill_valid,
                         bus.d_fill_valid, bus.i_done, bus.d_done, eg, ee, ev, ed);
            end
            checks++;
            if (bus.mem_addr !== ea) begin
                errors++;
                $display("FAIL i_fill_addr k=%0d: got %h required %h", k, bus.mem_addr, ea);
            end
            if (ev) begin
                edat = ~(16'h1230 + 16'(2 * (k - 5)));
                checks++;
                if (bus.fill_word_idx !== 3'(k - 5) || bus.fill_data !== edat) begin
                    errors++;
                    $display("FAIL i_fill_word k=%0d: got idx=%0d data=%h required idx=%0d data=%h",
                             k, bus.fill_word_idx, bus.fill_data, k - 5, edat);
                end
            end
            step();
            if (k == 12) bus.i_req = 1'b0;
        end
    endtask

    task automatic test_priority;
        logic        eig, edg, ee, edv, edd;
        logic [15:0] ea, edat;
        logic        seen;
        step();
        bus.i_req = 1'b1; bus.i_addr = 16'h4444;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h8000;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            edg = (k >= 1 && k <= 12);
            eig = (k >= 14);
            edv = (k >= 5 && k <= 12);
            edd = (k == 12);
            ee  = (k >= 1 && k <= 8) || (k >= 14);
            if (k >= 1 && k <= 8)  ea = 16'h8000 + 16'(2 * (k - 1));
            else if (k >= 14)      ea = 16'h4440 + 16'(2 * (k - 14));
            else                   ea = 16'h0000;
            checks++;
            if ({bus.i_grant, bus.d_grant, bus.mem_enable, bus.d_fill_valid, bus.i_fill_valid,
                 bus.d_done, bus.i_done} !== {eig, edg, ee, edv, 1'b0, edd, 1'b0}) begin
                errors++;
                $display("FAIL prio_flags k=%0d: got ig=%b dg=%b en=%b dv=%b iv=%b dd=%b id=%b, required ig=%b dg=%b en=%b dv=%b dd=%b",
                         k, bus.i_grant, bus.d_grant, bus.mem_enable, bus.d_fill_valid, bus.i_fill_valid,
                         bus.d_done, bus.i_done, eig, edg, ee, edv, edd);
            end
            checks++;
            if (bus.mem_addr !== ea) begin
                errors++;
                $display("FAIL prio_addr k=%0d: got %h required %h", k, bus.mem_addr, ea);
            end
            if (edv) begin
                edat = ~(16'h8000 + 16'(2 * (k - 5)));
                checks++;
                if (bus.fill_word_idx !== 3'(k - 5) || bus.fill_data !== edat) begin
                    errors++;
                    $display("FAIL prio_d_word k=%0d: got idx=%0d data=%h required idx=%0d data=%h",
                             k, bus.fill_word_idx, bus.fill_data, k - 5, edat);
                end
            end
            step();
            if (k == 12) bus.d_req = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (bus.i_done) seen = 1'b1;
            step();
        end
        bus.i_req = 1'b0;
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL prio_i_done: got %b required 1", seen);
        end
    endtask

    task automatic test_write;
        step();
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h00A6; bus.d_wdata = 16'hBEEF;
        step();
        @(negedge clk);
        checks++;
        if ({bus.mem_enable, bus.mem_wr, bus.d_grant, bus.d_done, bus.i_grant, bus.i_done} !== 6'b111100) begin
            errors++;
            $display("FAIL write_flags: got en=%b wr=%b dg=%b dd=%b ig=%b id=%b required 111100",
                     bus.mem_enable, bus.mem_wr, bus.d_grant, bus.d_done, bus.i_grant, bus.i_done);
        end
        checks++;
        if (bus.mem_addr !== 16'h00A6 || bus.mem_data_in !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_bus: got addr=%h data=%h required addr=00a6 data=beef",
                     bus.mem_addr, bus.mem_data_in);
        end
        step();
        bus.d_req = 1'b0; bus.d_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_addr, bus.mem_data_in, bus.mem_enable, bus.mem_wr, bus.d_grant, bus.d_done} !== 36'd0) begin
            errors++;
            $display("FAIL write_after: got addr=%h data=%h en=%b wr=%b dg=%b dd=%b required all 0",
                     bus.mem_addr, bus.mem_data_in, bus.mem_enable, bus.mem_wr, bus.d_grant, bus.d_done);
        end
    endtask

    task automatic test_reset_mid;
        step();
        bus.i_req = 1'b1; bus.i_addr = 16'h2468;
        step(); step(); step();
        rst = 1'b1;
        bus.i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.i_grant !== 1'b1 || bus.mem_addr !== 16'h2464) begin
            errors++;
            $display("FAIL rmid_before: got ig=%b addr=%h required ig=1 addr=2464", bus.i_grant, bus.mem_addr);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_addr, bus.mem_enable, bus.i_grant, bus.d_grant, bus.i_fill_valid,
             bus.fill_word_idx, bus.i_done, bus.d_done} !== 25'd0) begin
            errors++;
            $display("FAIL rmid_after: got addr=%h en=%b ig=%b iv=%b idx=%0d id=%b required all 0",
                     bus.mem_addr, bus.mem_enable, bus.i_grant, bus.i_fill_valid, bus.fill_word_idx, bus.i_done);
        end
        for (int k = 5; k <= 10; k++) begin
            step();
            @(negedge clk);
            checks++;
            if ({bus.i_fill_valid, bus.i_done, bus.i_grant} !== 3'b000) begin
                errors++;
                $display("FAIL rmid_late k=%0d: got iv=%b id=%b ig=%b required 000",
                         k, bus.i_fill_valid, bus.i_done, bus.i_grant);
            end
        end
        step(); step();
        bus.i_req = 1'b1; bus.i_addr = 16'h2468;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.mem_addr !== 16'h2460) begin
                    errors++;
                    $display("FAIL rmid_refill_addr: got %h required 2460", bus.mem_addr);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.i_fill_valid !== 1'b1 || bus.fill_word_idx !== 3'd0) begin
                    errors++;
                    $display("FAIL rmid_refill_first: got iv=%b idx=%0d required iv=1 idx=0",
                             bus.i_fill_valid, bus.fill_word_idx);
                end
            end
            if (k == 12) begin
                checks++;
                if (bus.i_done !== 1'b1 || bus.fill_word_idx !== 3'd7) begin
                    errors++;
                    $display("FAIL rmid_refill_done: got id=%b idx=%0d required id=1 idx=7",
                             bus.i_done, bus.fill_word_idx);
                end
            end
            step();
            if (k == 12) bus.i_req = 1'b0;
        end
    endtask

    task automatic test_drop;
        int n_iss, n_bad, n_done, n_val;
        n_iss = 0; n_bad = 0; n_done = 0; n_val = 0;
        step();
        bus.i_req = 1'b1; bus.i_addr = 16'h0F00;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (bus.mem_enable) begin
                n_iss++;
                if (bus.mem_addr !== 16'h0F00 + 16'(2 * (k - 1))) n_bad++;
            end
            if (bus.i_done) n_done++;
            if (bus.i_fill_valid) n_val++;
            step();
            if (k == 1) bus.i_req = 1'b0;
        end
        checks++;
        if (n_iss !== 8 || n_bad !== 0) begin
            errors++;
            $display("FAIL drop_issue: got issued=%0d bad_addr=%0d required issued=8 bad_addr=0", n_iss, n_bad);
        end
        checks++;
        if (n_done !== 1 || n_val !== 8) begin
            errors++;
            $display("FAIL drop_done: got done=%0d valids=%0d required done=1 valids=8", n_done, n_val);
        end
    endtask

    task automatic test_idle_valid;
        int   cnt, bad;
        logic seen;
        step();
        inj = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.i_fill_valid, bus.d_fill_valid, bus.i_grant, bus.d_grant, bus.mem_enable,
             bus.fill_word_idx} !== 8'd0) begin
            errors++;
            $display("FAIL idle_valid_pulse: got iv=%b dv=%b ig=%b dg=%b en=%b idx=%0d required all 0",
                     bus.i_fill_valid, bus.d_fill_valid, bus.i_grant, bus.d_grant, bus.mem_enable, bus.fill_word_idx);
        end
        step();
        inj = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.i_grant, bus.d_grant, bus.mem_enable, bus.fill_word_idx} !== 6'd0) begin
            errors++;
            $display("FAIL idle_valid_after: got ig=%b dg=%b en=%b idx=%0d required all 0",
                     bus.i_grant, bus.d_grant, bus.mem_enable, bus.fill_word_idx);
        end
        step();
        bus.i_req = 1'b1; bus.i_addr = 16'h5550;
        cnt = 0; bad = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.i_fill_valid) begin
                if (bus.fill_word_idx !== 3'(cnt)) bad++;
                cnt++;
            end
            if (bus.i_done) seen = 1'b1;
            step();
        end
        bus.i_req = 1'b0;
        checks++;
        if (cnt !== 8 || bad !== 0 || seen !== 1'b1) begin
            errors++;
            $display("FAIL idle_valid_fill: got words=%0d bad_idx=%0d done=%b required words=8 bad_idx=0 done=1",
                     cnt, bad, seen);
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_priority();
        test_write();
        test_reset_mid();
        test_drop();
        test_idle_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
